// File: rtl/shk_cfg_seq_if.sv
// shk_cfg_seq_if: shake bus between the config sequencer (master)
// and the shake-to-IIC bridge (slave).
interface shk_cfg_seq_if #(
  parameter int WD_SHK_DATA = 8,
  parameter int WD_SHK_ADDR = 16
);
  logic                   valid;
  logic                   msync;
  logic [WD_SHK_DATA-1:0] mdata;
  logic [WD_SHK_DATA-1:0] mdat1;
  logic [WD_SHK_ADDR-1:0] maddr;
  logic                   ready;
  logic                   ssync;
  logic [WD_SHK_DATA-1:0] sdata;

  modport master (
    output valid, msync, mdata, mdat1, maddr,
    input  ready, ssync, sdata
  );

  modport slave (
    input  valid, msync, mdata, mdat1, maddr,
    output ready, ssync, sdata
  );
endinterface

// File: rtl/shk_cfg_seq.sv
// shk_cfg_seq: walks a (dev, reg, dat) table and issues shake writes.
// Define SHK_CFG_READBACK_EN to read back and compare every write.
module shk_cfg_seq #(
  parameter int NB_SYS_PER  = 10,
  parameter int NB_DLY_UNIT = 1_000_000,
  parameter int NB_TMO_PER  = 50_000_000,
  parameter int NB_TBL_LEN  = 256,
  parameter int WD_TBL_ADDR = 8,
  parameter int WD_SHK_DATA = 8,
  parameter int WD_SHK_ADDR = 16,
  parameter int WD_ERR_INFO = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   i_cfg_start,
  output logic [WD_TBL_ADDR-1:0] m_tbl_addr,
  input  logic [8+WD_SHK_ADDR+WD_SHK_DATA-1:0] m_tbl_data,
  shk_cfg_seq_if.master          m_shk_0,
  output logic                   o_cfg_busy,
  output logic                   o_cfg_done,
  output logic [WD_ERR_INFO-1:0] m_err_info
);

  localparam int WD_ENT  = 8 + WD_SHK_ADDR + WD_SHK_DATA;
  localparam int TMO_CYC = NB_TMO_PER / NB_SYS_PER;
  localparam int DLY_CYC = NB_DLY_UNIT / NB_SYS_PER;
  localparam int DLY_MAX = ((1 << WD_SHK_DATA) - 1) * DLY_CYC;
  localparam int TMR_MAX = (TMO_CYC > DLY_MAX) ? TMO_CYC : DLY_MAX;
  localparam int WD_TMR  = $clog2(TMR_MAX + 1);
  localparam bit HI_EN   = WD_SHK_ADDR > 8;

  localparam logic [1:0] LAST_WR = HI_EN ? 2'd3 : 2'd2;
  localparam logic [WD_TMR-1:0] TMO_LAST = WD_TMR'(TMO_CYC - 1);
  localparam logic [WD_TBL_ADDR-1:0] IDX_LAST =
    WD_TBL_ADDR'(NB_TBL_LEN - 1);

  localparam logic [WD_ERR_INFO-1:0] ERR_TMO = WD_ERR_INFO'(1);
  localparam logic [WD_ERR_INFO-1:0] ERR_RBK = WD_ERR_INFO'(2);
  localparam logic [WD_ERR_INFO-1:0] ERR_END = WD_ERR_INFO'(3);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DELAY = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]             state_q, state_d;
  logic [WD_TBL_ADDR-1:0] idx_q, idx_d;
  logic [WD_ENT-1:0]      ent_q, ent_d;
  logic [1:0]             bcnt_q, bcnt_d;
  logic [WD_TMR-1:0]      tmr_q, tmr_d;
  logic [WD_ERR_INFO-1:0] err_q, err_d;

  logic [7:0]             dev_w, tdev_w, byte_w;
  logic [WD_SHK_ADDR-1:0] rga_w;
  logic [WD_SHK_DATA-1:0] dat_w, tdat_w;
  logic [15:0]            rg16_w;
  logic [1:0]             bsel_w, last_w;
  logic [WD_TMR-1:0]      dly_last_w;
  logic                   adv_w;

  assign {dev_w, rga_w, dat_w} = ent_q;
  assign tdev_w = m_tbl_data[WD_ENT-1 -: 8];
  assign tdat_w = m_tbl_data[WD_SHK_DATA-1:0];
  assign rg16_w = 16'(rga_w);
  assign dly_last_w = WD_TMR'(int'(dat_w) * DLY_CYC - 1);

  // A narrow register address skips the high byte of the burst.
  always_comb begin
    bsel_w = (HI_EN || bcnt_q == 2'd0) ? bcnt_q : bcnt_q + 2'd1;
    unique case (bsel_w)
      2'd0:    byte_w = {dev_w[6:0], 1'b0};
      2'd1:    byte_w = rg16_w[15:8];
      2'd2:    byte_w = rg16_w[7:0];
      default: byte_w = 8'(dat_w);
    endcase
  end

`ifdef SHK_CFG_READBACK_EN
  logic                   rd_q, rd_d;
  logic [WD_SHK_DATA-1:0] rbk_q, rbk_d, rbk_w;

  assign rbk_w  = m_shk_0.ssync ? m_shk_0.sdata : rbk_q;
  assign last_w = rd_q ? LAST_WR - 2'd1 : LAST_WR;
  assign m_shk_0.mdat1 = (state_q == S_ISSUE && rd_q) ?
                         WD_SHK_DATA'(1) : '0;
`else
  logic unused_rbk;

  assign unused_rbk = ^{m_shk_0.ssync, m_shk_0.sdata};
  assign last_w = LAST_WR;
  assign m_shk_0.mdat1 = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ent_d   = ent_q;
    bcnt_d  = bcnt_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    adv_w   = 1'b0;
`ifdef SHK_CFG_READBACK_EN
    rd_d    = rd_q;
    rbk_d   = rbk_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_cfg_start) begin
          idx_d   = '0;
          err_d   = '0;
          bcnt_d  = '0;
          state_d = S_FETCH;
`ifdef SHK_CFG_READBACK_EN
          rd_d    = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (bcnt_q == 2'd0) begin
          bcnt_d = 2'd1;
        end else begin
          ent_d  = m_tbl_data;
          bcnt_d = '0;
          tmr_d  = '0;
          if (tdev_w == 8'h00) begin
            state_d = S_DONE;
          end else if (tdev_w == 8'hFF) begin
            if (tdat_w == '0) idx_d = idx_q + 1'b1;
            else              state_d = S_DELAY;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        bcnt_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bcnt_q == last_w) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end else begin
          bcnt_d = bcnt_q + 2'd1;
        end
      end
      S_WAIT: begin
`ifdef SHK_CFG_READBACK_EN
        if (rd_q && m_shk_0.ssync) rbk_d = m_shk_0.sdata;
`endif
        if (m_shk_0.ready) begin
`ifdef SHK_CFG_READBACK_EN
          if (!rd_q) begin
            rd_d    = 1'b1;
            state_d = S_ISSUE;
          end else if (rbk_w != dat_w) begin
            err_d   = ERR_RBK;
            state_d = S_ERR;
          end else begin
            rd_d  = 1'b0;
            adv_w = 1'b1;
          end
`else
          adv_w = 1'b1;
`endif
        end else if (tmr_q == TMO_LAST) begin
          err_d   = ERR_TMO;
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DELAY: begin
        if (tmr_q == dly_last_w) begin
          idx_d   = idx_q + 1'b1;
          bcnt_d  = '0;
          state_d = S_FETCH;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completed write on the last slot means the table had no end marker.
    if (adv_w) begin
      if (idx_q == IDX_LAST) begin
        err_d   = ERR_END;
        state_d = S_ERR;
      end else begin
        idx_d   = idx_q + 1'b1;
        bcnt_d  = '0;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ent_q   <= '0;
      bcnt_q  <= '0;
      tmr_q   <= '0;
      err_q   <= '0;
`ifdef SHK_CFG_READBACK_EN
      rd_q    <= 1'b0;
      rbk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ent_q   <= ent_d;
      bcnt_q  <= bcnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`ifdef SHK_CFG_READBACK_EN
      rd_q    <= rd_d;
      rbk_q   <= rbk_d;
`endif
    end
  end

  assign m_tbl_addr    = idx_q;
  assign m_err_info    = err_q;
  assign o_cfg_done    = state_q == S_DONE;
  assign o_cfg_busy    = !(state_q == S_IDLE || state_q == S_DONE ||
                           state_q == S_ERR);
  assign m_shk_0.valid = state_q == S_ISSUE;
  assign m_shk_0.msync = state_q == S_SEND;
  assign m_shk_0.mdata = (state_q == S_SEND) ? WD_SHK_DATA'(byte_w) : '0;
  assign m_shk_0.maddr = (state_q == S_ISSUE) ? rga_w : '0;

endmodule
